// File: rtl/mem_pkg.sv
// Shared types and constants for the memory port arbiter.
//   mem_arb_state_t : arbiter FSM states (IDLE, F0, F1, F2, D0, D1)
//   requester_t     : identifies the fetch or data requester
//   INSTR_BYTES     : bytes read per instruction fetch
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    F0,
    F1,
    F2,
    D0,
    D1
  } mem_arb_state_t;

  typedef enum logic {
    REQ_FETCH,
    REQ_DATA
  } requester_t;

  localparam int INSTR_BYTES = 2;

endpackage

// File: rtl/arb_select.sv
// Winner selection between the fetch and data requesters.
// Build option: MEM_ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, data beats fetch.
//   defined   : alternating priority on contended arbitrations, tracked by a
//               last_winner register (resets to data, so fetch wins first).
// Ports:
//   clk, reset  : clock / async active-high reset (round-robin build only)
//   arb_en      : arbitration window (arbiter is in IDLE)
//   fetch_req   : fetch request level
//   data_req    : data request level
//   grant_valid : some requester wins this cycle
//   winner      : which requester wins (meaningful only with grant_valid)
module arb_select
  import mem_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic       clk,
  input  logic       reset,
`endif
  input  logic       arb_en,
  input  logic       fetch_req,
  input  logic       data_req,
  output logic       grant_valid,
  output requester_t winner
);

  assign grant_valid = arb_en && (fetch_req || data_req);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  requester_t last_winner;

  always_comb begin
    winner = REQ_DATA;
    if (fetch_req && data_req) begin
      // Contended: the side that lost last time goes first.
      winner = (last_winner == REQ_DATA) ? REQ_FETCH : REQ_DATA;
    end else if (fetch_req) begin
      winner = REQ_FETCH;
    end
  end

  // Only contended grants move the pointer; uncontended ones leave it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_winner <= REQ_DATA;
    end else if (arb_en && fetch_req && data_req) begin
      last_winner <= winner;
    end
  end
`else
  always_comb begin
    winner = REQ_DATA;
    if (fetch_req && !data_req) begin
      winner = REQ_FETCH;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port memory between the instruction-fetch path (two-byte
// reads, high byte at A, low byte at A+1 with wrap) and the data load/store
// path (single-byte reads/writes). Owns every memory enable.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration on
// simultaneous requests (see arb_select); default is data-first priority.
// Ports:
//   clk, reset                 : clock, async active-high reset
//   fetch_req/fetch_addr       : fetch request and instruction address
//   fetch_gnt                  : one-cycle grant (high during F0)
//   fetch_rdata/fetch_rvalid   : {mem[A], mem[A+1]} and its one-cycle valid
//   data_req/data_we/data_addr/data_wdata : data request
//   data_gnt                   : one-cycle grant (high during D0)
//   data_rdata/data_rvalid     : read byte and its one-cycle valid (reads only)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory port, one-cycle read
//                                latency
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             fetch_req,
  input  logic [ADDR_BITS-1:0]             fetch_addr,
  output logic                             fetch_gnt,
  output logic [INSTR_BYTES*DATA_BITS-1:0] fetch_rdata,
  output logic                             fetch_rvalid,
  input  logic                             data_req,
  input  logic                             data_we,
  input  logic [ADDR_BITS-1:0]             data_addr,
  input  logic [DATA_BITS-1:0]             data_wdata,
  output logic                             data_gnt,
  output logic [DATA_BITS-1:0]             data_rdata,
  output logic                             data_rvalid,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [ADDR_BITS-1:0]             mem_addr,
  output logic [DATA_BITS-1:0]             mem_wdata,
  input  logic [DATA_BITS-1:0]             mem_rdata
);

  mem_arb_state_t       state, state_next;
  logic [ADDR_BITS-1:0] addr_reg;
  logic                 we_reg;
  logic [DATA_BITS-1:0] wdata_reg;
  logic [DATA_BITS-1:0] hi_byte_reg;
  logic                 grant_valid;
  requester_t           winner;
  logic                 arb_en;

  assign arb_en = (state == IDLE);

  arb_select u_arb_select (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .clk         (clk),
    .reset       (reset),
`endif
    .arb_en      (arb_en),
    .fetch_req   (fetch_req),
    .data_req    (data_req),
    .grant_valid (grant_valid),
    .winner      (winner)
  );

  // Next state and memory-side outputs. Outputs decode the current state so
  // that an asynchronous reset (state -> IDLE) zeroes them immediately.
  always_comb begin
    state_next = state;
    fetch_gnt  = 1'b0;
    data_gnt   = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_next = (winner == REQ_DATA) ? D0 : F0;
        end
      end
      F0: begin
        fetch_gnt  = 1'b1;
        mem_en     = 1'b1;
        mem_addr   = addr_reg;
        state_next = F1;
      end
      F1: begin
        mem_en     = 1'b1;
        mem_addr   = addr_reg + ADDR_BITS'(1);  // wraps modulo 2^ADDR_BITS
        state_next = F2;
      end
      F2: begin
        state_next = IDLE;
      end
      D0: begin
        data_gnt   = 1'b1;
        mem_en     = 1'b1;
        mem_we     = we_reg;
        mem_addr   = addr_reg;
        mem_wdata  = we_reg ? wdata_reg : '0;
        state_next = we_reg ? IDLE : D1;
      end
      D1: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      addr_reg     <= '0;
      we_reg       <= 1'b0;
      wdata_reg    <= '0;
      hi_byte_reg  <= '0;
      fetch_rdata  <= '0;
      fetch_rvalid <= 1'b0;
      data_rdata   <= '0;
      data_rvalid  <= 1'b0;
    end else begin
      state        <= state_next;
      fetch_rvalid <= 1'b0;
      data_rvalid  <= 1'b0;
      if (state == IDLE && grant_valid) begin
        addr_reg  <= (winner == REQ_DATA) ? data_addr : fetch_addr;
        we_reg    <= (winner == REQ_DATA) && data_we;
        wdata_reg <= (winner == REQ_DATA) ? data_wdata : '0;
      end
      // Byte at A arrives during F1; byte at A+1 during F2. The high byte is
      // staged so fetch_rdata changes only together with fetch_rvalid.
      if (state == F1) begin
        hi_byte_reg <= mem_rdata;
      end
      if (state == F2) begin
        fetch_rdata  <= {hi_byte_reg, mem_rdata};
        fetch_rvalid <= 1'b1;
      end
      if (state == D1) begin
        data_rdata  <= mem_rdata;
        data_rvalid <= 1'b1;
      end
    end
  end

endmodule
